// File: rtl/axi_node_aw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_node_aw_pkg
// Purpose  : Shared AW-channel constants, awctrl field offsets and the
//            allocator state type for the AXI node.
// Revision : 1.0 - initial release
// ============================================================================
package axi_node_aw_pkg;

    // Width of the packed {len,size,burst,lock,cache,prot,region,qos} bundle
    localparam int AW_CTRL_W     = 29;

    // Bit offsets of each awctrl field (qos sits at the LSB end)
    localparam int AW_QOS_OFF    = 0;
    localparam int AW_REGION_OFF = 4;
    localparam int AW_PROT_OFF   = 8;
    localparam int AW_CACHE_OFF  = 11;
    localparam int AW_LOCK_OFF   = 15;
    localparam int AW_BURST_OFF  = 16;
    localparam int AW_SIZE_OFF   = 18;
    localparam int AW_LEN_OFF    = 21;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } aw_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_multiplexer.sv
`default_nettype none
// ============================================================================
// Module   : axi_multiplexer
// Purpose  : Generic N-input binary-select data multiplexer. Out-of-range
//            selects yield zero.
// Revision : 1.0 - initial release
// ============================================================================
module axi_multiplexer #(
    parameter int DATA_WIDTH = 32,
    parameter int N_IN       = 2,
    parameter int SEL_WIDTH  = 1
) (
    input  logic [N_IN-1:0][DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]            sel,
    output logic [DATA_WIDTH-1:0]           out_data
);

    // Select the addressed input; unmatched selects leave the default zero
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_WIDTH'(i)) out_data = in_data[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rr_arbiter_tree.sv
`default_nettype none
// ============================================================================
// Module   : axi_rr_arbiter_tree
// Purpose  : Combinational round-robin pick: the first requester at or after
//            rr_ptr_i wins, wrapping modulo N_REQ. Shared by AW/AR allocators.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rr_arbiter_tree #(
    parameter int N_REQ = 7,
    parameter int LOG_N = (N_REQ == 1) ? 1 : $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [LOG_N-1:0] rr_ptr_i,
    output logic             gnt_valid_o,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [LOG_N-1:0] gnt_bin_o
);

    int               w_sum;
    logic [LOG_N-1:0] w_idx;

    // Scan requesters starting at the pointer; keep only the first hit
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_oh_o    = '0;
        gnt_bin_o   = '0;
        w_sum       = 0;
        w_idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = int'(rr_ptr_i) + i;
            if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
            w_idx = LOG_N'(w_sum);
            if (!gnt_valid_o && req_i[w_idx]) begin
                gnt_valid_o     = 1'b1;
                gnt_bin_o       = w_idx;
                gnt_oh_o[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_aw_rr_allocator.sv
`default_nettype none
// ============================================================================
// Module   : axi_aw_rr_allocator
// Purpose  : Round-robin AW allocator for one initiator port. Muxes the
//            winning target port onto the slave AW channel, extends AWID with
//            the winner index and pushes {BIN,OH} into the W-allocator ID FIFO.
//            Optional macro AXI_AW_OUT_REG_EN inserts a one-entry output slice.
// Revision : 1.0 - initial release
// ============================================================================
module axi_aw_rr_allocator
    import axi_node_aw_pkg::*;
#(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_USER_W    = 6,
    parameter int AXI_ID_IN     = 4,
    parameter int N_TARG_PORT   = 7,
    parameter int LOG_N_TARG    = (N_TARG_PORT == 1) ? 1 : $clog2(N_TARG_PORT),
    parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]     awid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0] awaddr_i,
    input  logic [N_TARG_PORT-1:0][AW_CTRL_W-1:0]     awctrl_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    awuser_i,
    input  logic [N_TARG_PORT-1:0]                    awvalid_i,
    output logic [N_TARG_PORT-1:0]                    awready_o,
    output logic [AXI_ID_OUT-1:0]                     awid_o,
    output logic [AXI_ADDRESS_W-1:0]                  awaddr_o,
    output logic [AW_CTRL_W-1:0]                      awctrl_o,
    output logic [AXI_USER_W-1:0]                     awuser_o,
    output logic                                      awvalid_o,
    input  logic                                      awready_i,
    output logic                                      push_ID_o,
    output logic [LOG_N_TARG+N_TARG_PORT-1:0]         ID_o,
    input  logic                                      grant_FIFO_ID_i
);

    localparam int                  c_pay_w    = AXI_ID_IN + AXI_ADDRESS_W + AW_CTRL_W + AXI_USER_W;
    localparam logic [LOG_N_TARG-1:0] c_last_idx = LOG_N_TARG'(N_TARG_PORT - 1);

    aw_state_e                              r_state, w_state_nxt;
    logic [LOG_N_TARG-1:0]                  r_ptr, r_lock_bin;
    logic                                   w_arb_valid;
    logic [N_TARG_PORT-1:0]                 w_arb_oh;
    logic [LOG_N_TARG-1:0]                  w_arb_bin, w_sel_bin, w_out_bin;
    logic [N_TARG_PORT-1:0]                 w_sel_oh;
    logic                                   w_req_valid, w_dn_ready, w_load, w_out_valid;
    logic [N_TARG_PORT-1:0][c_pay_w-1:0]    w_pay_in;
    logic [c_pay_w-1:0]                     w_pay_sel, w_pay_out;

    for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_pay_pack
        assign w_pay_in[p] = {awid_i[p], awaddr_i[p], awctrl_i[p], awuser_i[p]};
    end

    axi_rr_arbiter_tree #(
        .N_REQ (N_TARG_PORT),
        .LOG_N (LOG_N_TARG)
    ) u_arb (
        .req_i       (awvalid_i),
        .rr_ptr_i    (r_ptr),
        .gnt_valid_o (w_arb_valid),
        .gnt_oh_o    (w_arb_oh),
        .gnt_bin_o   (w_arb_bin)
    );

    // While locked the latched winner steers everything, else the live arbiter
    assign w_sel_bin = (r_state == LOCK) ? r_lock_bin : w_arb_bin;

    axi_multiplexer #(
        .DATA_WIDTH (c_pay_w),
        .N_IN       (N_TARG_PORT),
        .SEL_WIDTH  (LOG_N_TARG)
    ) u_pay_mux (
        .in_data  (w_pay_in),
        .sel      (w_sel_bin),
        .out_data (w_pay_sel)
    );

    // One-hot form of the selected port
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (w_sel_bin == LOG_N_TARG'(i)) w_sel_oh[i] = 1'b1;
        end
    end

    // Request toward the downstream stage; held low throughout reset. A full
    // ID FIFO only blocks new arbitration since nobody else pushes during LOCK.
    assign w_req_valid = rst_n & ((r_state == LOCK) ? awvalid_i[r_lock_bin]
                                                    : (w_arb_valid & grant_FIFO_ID_i));
    assign w_load      = w_req_valid & w_dn_ready;

`ifdef AXI_AW_OUT_REG_EN
    logic                  r_slice_valid;
    logic [c_pay_w-1:0]    r_slice_pay;
    logic [LOG_N_TARG-1:0] r_slice_bin;

    assign w_dn_ready = ~r_slice_valid | awready_i;

    // Output slice: load on arbiter handshake, drain on slave handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slice_valid <= 1'b0;
            r_slice_pay   <= '0;
            r_slice_bin   <= '0;
        end else if (w_load) begin
            r_slice_valid <= 1'b1;
            r_slice_pay   <= w_pay_sel;
            r_slice_bin   <= w_sel_bin;
        end else if (awready_i) begin
            r_slice_valid <= 1'b0;
        end
    end

    assign w_out_valid = r_slice_valid;
    assign w_pay_out   = r_slice_pay;
    assign w_out_bin   = r_slice_bin;
`else
    assign w_dn_ready  = awready_i;
    assign w_out_valid = w_req_valid;
    assign w_pay_out   = rst_n ? w_pay_sel : '0;
    assign w_out_bin   = rst_n ? w_sel_bin : '0;
`endif

    // State, lock index and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB;
            r_ptr      <= '0;
            r_lock_bin <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB && w_state_nxt == LOCK) r_lock_bin <= w_arb_bin;
            if (w_load) r_ptr <= (w_sel_bin == c_last_idx) ? '0 : w_sel_bin + LOG_N_TARG'(1);
        end
    end

    // Next state: a stalled request freezes the winner until accepted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_req_valid && !w_dn_ready) w_state_nxt = LOCK;
            LOCK:    if (w_dn_ready) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    // Outputs: port accept, ID FIFO push and slave-side AW channel
    always_comb begin
        awready_o = w_load ? w_sel_oh : '0;
        push_ID_o = w_load;
        ID_o      = rst_n ? {w_sel_bin, w_sel_oh} : '0;
        awvalid_o = w_out_valid;
        awid_o    = {w_out_bin, w_pay_out[c_pay_w-1 -: AXI_ID_IN]};
        awaddr_o  = w_pay_out[AW_CTRL_W+AXI_USER_W +: AXI_ADDRESS_W];
        awctrl_o  = w_pay_out[AXI_USER_W +: AW_CTRL_W];
        awuser_o  = w_pay_out[AXI_USER_W-1:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_aw_rr_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_aw_rr_allocator
// Purpose  : Self-checking bench for axi_aw_rr_allocator (combinational
//            output build) with a reference model and expected-push queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_aw_rr_allocator;

    localparam int N   = 7;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int UW  = 6;
    localparam int CW  = 29;
    localparam int LG  = 3;
    localparam int IDO = IDW + LG;

    typedef struct packed {
        logic [LG+N-1:0] id;
        logic [IDO-1:0]  awid;
        logic [AW-1:0]   addr;
        logic [CW-1:0]   ctrl;
        logic [UW-1:0]   user;
        logic [N-1:0]    rdy;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0][IDW-1:0] awid_i;
    logic [N-1:0][AW-1:0]  awaddr_i;
    logic [N-1:0][CW-1:0]  awctrl_i;
    logic [N-1:0][UW-1:0]  awuser_i;
    logic [N-1:0]          awvalid_i;
    logic [N-1:0]          awready_o;
    logic [IDO-1:0]        awid_o;
    logic [AW-1:0]         awaddr_o;
    logic [CW-1:0]         awctrl_o;
    logic [UW-1:0]         awuser_o;
    logic                  awvalid_o;
    logic                  awready_i;
    logic                  push_ID_o;
    logic [LG+N-1:0]       ID_o;
    logic                  grant_FIFO_ID_i;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb_q[$];
    int   m_ptr   = 0;
    bit   m_lock  = 0;
    int   m_lw    = 0;

    always #5 clk = ~clk;

    axi_aw_rr_allocator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .awid_i          (awid_i),
        .awaddr_i        (awaddr_i),
        .awctrl_i        (awctrl_i),
        .awuser_i        (awuser_i),
        .awvalid_i       (awvalid_i),
        .awready_o       (awready_o),
        .awid_o          (awid_o),
        .awaddr_o        (awaddr_o),
        .awctrl_o        (awctrl_o),
        .awuser_o        (awuser_o),
        .awvalid_o       (awvalid_o),
        .awready_i       (awready_i),
        .push_ID_o       (push_ID_o),
        .ID_o            (ID_o),
        .grant_FIFO_ID_i (grant_FIFO_ID_i)
    );

    function automatic int m_winner(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    // Model one cycle from current inputs; queue the expected push if any
    task automatic sb_expect(output bit ev, output int ew, output bit eh);
        exp_t e;
        ew = m_lock ? m_lw : m_winner(awvalid_i, m_ptr);
        ev = m_lock ? awvalid_i[ew] : ((|awvalid_i) && grant_FIFO_ID_i);
        eh = ev && awready_i;
        if (eh) begin
            e.id   = {LG'(ew), N'(1) << ew};
            e.awid = {LG'(ew), awid_i[ew]};
            e.addr = awaddr_i[ew];
            e.ctrl = awctrl_i[ew];
            e.user = awuser_i[ew];
            e.rdy  = N'(1) << ew;
            sb_q.push_back(e);
        end
    endtask

    task automatic m_advance(input bit ev, input int ew);
        if (ev && awready_i) begin
            m_ptr  = (ew == N - 1) ? 0 : ew + 1;
            m_lock = 0;
        end else if (ev && !m_lock) begin
            m_lock = 1;
            m_lw   = ew;
        end
    endtask

    function automatic exp_t actual();
        return {ID_o, awid_o, awaddr_o, awctrl_o, awuser_o, awready_o};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
        #1;
        n_total++; if (awvalid_o !== 1'b0) $display("FAIL reset_awvalid got %b want 0", awvalid_o); else n_pass++;
        n_total++; if (awready_o !== '0) $display("FAIL reset_awready got %b want 0", awready_o); else n_pass++;
        n_total++; if (push_ID_o !== 1'b0) $display("FAIL reset_push got %b want 0", push_ID_o); else n_pass++;
        n_total++; if (awaddr_o !== '0) $display("FAIL reset_awaddr got %h want 0", awaddr_o); else n_pass++;
        n_total++; if (awid_o !== '0) $display("FAIL reset_awid got %h want 0", awid_o); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; awvalid_i = '0;
    endtask

    task automatic test_rr_pair();
        bit ev, eh; int ew; exp_t e;
        int seq[4] = '{2, 5, 2, 5};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            awvalid_i = 7'b0100100; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
            sb_expect(ev, ew, eh);
            #1;
            n_total++; if (awvalid_o !== ev || push_ID_o !== eh) $display("FAIL rr_pair_vp cyc %0d got %b%b want %b%b", c, awvalid_o, push_ID_o, ev, eh); else n_pass++;
            if (push_ID_o && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_total++; if (actual() !== e) $display("FAIL rr_pair_data cyc %0d got %h want %h", c, actual(), e); else n_pass++;
                n_total++; if (int'(ID_o[LG+N-1:N]) !== seq[c]) $display("FAIL rr_pair_port cyc %0d got %0d want %0d", c, ID_o[LG+N-1:N], seq[c]); else n_pass++;
            end
            m_advance(ev, ew);
        end
    endtask

    task automatic test_lock_hold();
        bit ev, eh; int ew; exp_t e; int pushes = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            awvalid_i = (c == 0) ? 7'b0001000 : 7'b0001001;
            awready_i = (c == 4); grant_FIFO_ID_i = 1'b1;
            sb_expect(ev, ew, eh);
            #1;
            if (push_ID_o) pushes++;
            n_total++; if (awvalid_o !== ev || push_ID_o !== eh) $display("FAIL lock_vp cyc %0d got %b%b want %b%b", c, awvalid_o, push_ID_o, ev, eh); else n_pass++;
            n_total++; if (awaddr_o !== awaddr_i[3] || awid_o !== {3'd3, awid_i[3]}) $display("FAIL lock_payload cyc %0d got %h want %h", c, awaddr_o, awaddr_i[3]); else n_pass++;
            if (c < 4) begin
                n_total++; if (awready_o !== '0) $display("FAIL lock_awready cyc %0d got %b want 0", c, awready_o); else n_pass++;
            end
            if (push_ID_o && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_total++; if (actual() !== e) $display("FAIL lock_data got %h want %h", actual(), e); else n_pass++;
            end
            m_advance(ev, ew);
        end
        n_total++; if (pushes !== 1) $display("FAIL lock_push_count got %0d want 1", pushes); else n_pass++;
    endtask

    task automatic test_fifo_full();
        bit ev, eh; int ew; exp_t e; int start_ptr;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = (c == 3);
            start_ptr = m_ptr;
            sb_expect(ev, ew, eh);
            #1;
            n_total++; if (awvalid_o !== ev || push_ID_o !== eh) $display("FAIL full_vp cyc %0d got %b%b want %b%b", c, awvalid_o, push_ID_o, ev, eh); else n_pass++;
            if (c < 3) begin
                n_total++; if (awready_o !== '0) $display("FAIL full_awready cyc %0d got %b want 0", c, awready_o); else n_pass++;
            end
            if (push_ID_o && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_total++; if (actual() !== e) $display("FAIL full_data got %h want %h", actual(), e); else n_pass++;
                n_total++; if (int'(ID_o[LG+N-1:N]) !== start_ptr) $display("FAIL full_first_port got %0d want %0d", ID_o[LG+N-1:N], start_ptr); else n_pass++;
            end
            m_advance(ev, ew);
        end
    endtask

    task automatic test_all_ports();
        bit ev, eh; int ew; exp_t e; int cnt[N];
        for (int p = 0; p < N; p++) cnt[p] = 0;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            awvalid_i = '1; awready_i = 1'b1; grant_FIFO_ID_i = 1'b1;
            sb_expect(ev, ew, eh);
            #1;
            n_total++; if (awvalid_o !== ev || push_ID_o !== eh) $display("FAIL all_vp cyc %0d got %b%b want %b%b", c, awvalid_o, push_ID_o, ev, eh); else n_pass++;
            if (push_ID_o && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cnt[ID_o[LG+N-1:N]]++;
                n_total++; if (actual() !== e) $display("FAIL all_data cyc %0d got %h want %h", c, actual(), e); else n_pass++;
            end
            m_advance(ev, ew);
        end
        for (int p = 0; p < N; p++) begin
            n_total++; if (cnt[p] !== 2) $display("FAIL all_fair port %0d got %0d want 2", p, cnt[p]); else n_pass++;
        end
    endtask

    task automatic test_reset_in_lock();
        bit ev, eh; int ew; exp_t e;
        @(negedge clk);
        awvalid_i = 7'b0100000; awready_i = 1'b0; grant_FIFO_ID_i = 1'b1;
        sb_expect(ev, ew, eh);
        #1;
        n_total++; if (awvalid_o !== 1'b1) $display("FAIL rstlock_pre got %b want 1", awvalid_o); else n_pass++;
        m_advance(ev, ew);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (awvalid_o !== 1'b0) $display("FAIL rstlock_awvalid got %b want 0", awvalid_o); else n_pass++;
        n_total++; if (awready_o !== '0 || push_ID_o !== 1'b0) $display("FAIL rstlock_rdy_push got %b/%b want 0/0", awready_o, push_ID_o); else n_pass++;
        m_ptr = 0; m_lock = 0;
        @(negedge clk); rst_n = 1'b1;
        awvalid_i = '1; awready_i = 1'b1;
        sb_expect(ev, ew, eh);
        #1;
        n_total++; if (push_ID_o !== 1'b1) $display("FAIL rstlock_post_push got %b want 1", push_ID_o); else n_pass++;
        if (push_ID_o && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_total++; if (actual() !== e) $display("FAIL rstlock_post_data got %h want %h", actual(), e); else n_pass++;
            n_total++; if (ID_o[LG+N-1:N] !== 3'd0) $display("FAIL rstlock_first_port got %0d want 0", ID_o[LG+N-1:N]); else n_pass++;
        end
        m_advance(ev, ew);
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            awid_i[p]   = IDW'(p + 3);
            awaddr_i[p] = 32'hA000_0005 | (32'(p) << 8);
            awctrl_i[p] = CW'(p * 1234567 + 1);
            awuser_i[p] = UW'(p * 5 + 1);
        end
        awvalid_i = '0; awready_i = 1'b0; grant_FIFO_ID_i = 1'b0; rst_n = 1'b0;
        test_reset();
        test_rr_pair();
        test_lock_hold();
        test_fifo_full();
        test_all_ports();
        test_reset_in_lock();
        n_total++; if (sb_q.size() !== 0) $display("FAIL sb_leftover got %0d want 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
